mult_share_arbiter: RTL and testbench
=====================================

// Module: mult_share_arbiter
// PURPOSE
//   Shares one combinational signed NxN multiplier among NREQ requesters.
//   Each requester issues operands over a valid/ready handshake. A round-robin arbiter grants one request per cycle.
//   The 2N-bit product is registered and returned with the requester ID on one response port that accepts backpressure.
//   Sits between client engines and the multiplier datapath.
// PARAMETERS
//   N     32  operand width, two's complement signed
//   NREQ  4   number of requesters, 2..16
//   IDW   $clog2(NREQ)  requester ID width (derived, not overridable)
// PORTS
//   clk        in   1         rising-edge clock, single clock domain
//   rst_n      in   1         synchronous reset, active-low
//   req_valid  in   NREQ      per-requester request strobe
//   req_ready  out  NREQ      per-requester accept; one-hot or zero
//   req_a      in   NREQ*N    operand A, requester i at [i*N +: N]
//   req_b      in   NREQ*N    operand B, requester i at [i*N +: N]
//   rsp_valid  out  1         response register holds a product
//   rsp_ready  in   1         consumer accepts the response
//   rsp_id     out  IDW       index of the requester that owns rsp_product
//   rsp_prod   out  2N        signed product A*B, full width
//   ops_done   out  16        count of completed responses, wraps
// BEHAVIOUR
//   - Reset (rst_n=0 at clk edge): rsp_valid=0, rsp_id=0, rsp_prod=0, ops_done=0, rr_ptr=0.
//     req_ready=0 while rst_n=0. Reset mid-transaction drops the held response.
//   - slot_free = !rsp_valid | rsp_ready (combinational).
//   - Arbitration:
//     - Search req_valid starting at rr_ptr, then upward with wrap-around. The first set bit wins.
//     - req_ready[g] = slot_free & req_valid[g]. No grant when no valid or !slot_free.
//   - Accept (valid&ready for winner g) at edge t: rsp_prod <= signed(a_g)*signed(b_g);
//     rsp_id <= g; rsp_valid <= 1; rr_ptr <= (g+1) mod NREQ.
//   - Latency: the response is visible in the cycle after acceptance. Throughput is 1 op/clk with rsp_ready held high.
//   - Response: rsp_valid stays 1 and rsp_prod/rsp_id stay stable until rsp_valid&rsp_ready.
//     When the slot drains with no new accept, rsp_valid <= 0.
//     Drain and accept in the same cycle load the new product without a bubble.
//   - ops_done increments on each rsp_valid&rsp_ready and wraps 0xFFFF->0.
//   - rr_ptr moves only on an accept. Idle cycles and backpressure leave it unchanged. This holds fairness:
//     a continuously valid requester waits at most NREQ-1 grants.
//   - Arithmetic: operands are sign-extended to 2N, so the product is exact with no overflow.
//     Example: (-2^(N-1))*(-2^(N-1)) = 2^(2N-2).
//   - Requesters must hold a, b and valid stable until ready. A valid that drops before ready is not an error.
//   - Requester i with valid high while not granted sees ready=0. A grant is never given to an invalid requester.
// STRUCTURE
//   - mult_pkg: N default, NREQ default, ID width function, product type width constant.
//   - Sub-module rr_arbiter (NREQ): inputs req, ptr; outputs one-hot gnt and gnt_idx. Purely combinational.
//   - The multiplier is the team's existing signed combinational core, instantiated once, with its inputs muxed by gnt_idx.
//   - Top level holds the response register, rr_ptr register and ops_done counter.
// TESTING
//   1 Reset: drive rst_n=0 for 2 clk with all req_valid=1.
//     -> req_ready=0, rsp_valid=0, ops_done=0. First grant after release goes to id 0.
//   2 Signed products: each of these on req 0, rsp_ready=1 -> rsp_prod/rsp_id=0, one cycle later.
//     - 5*6 -> 30
//     - -4*-7 -> 28
//     - 10*-4 -> -40
//     - -50*5 -> -250
//     - 1234*0 -> 0
//     - 99*1 -> 99
//     - (-2^31)*(-2^31) -> 2^62
//   3 Round-robin: all 4 valid continuously with a_i=i+1, b_i=10, rsp_ready=1.
//     -> ids 0,1,2,3,0,... and products 10,20,30,40,10. Back-to-back, no bubbles.
//   4 Backpressure: rsp_ready=0 for 5 clk after one accept.
//     -> rsp_valid=1 and rsp_prod/rsp_id stable, req_ready all 0.
//     -> on rsp_ready=1, drain and next accept happen in the same cycle.
//   5 Wrap/fairness: only req 3 and req 1 valid, rr_ptr=2. -> grant 3, then 1, then 3.
//     Counter check: 65537 drained ops -> ops_done=1.
//   6 Reset mid-op: assert rst_n=0 while rsp_valid=1 and rsp_ready=0.
//     -> next cycle rsp_valid=0, the product is dropped, rr_ptr=0.

Source files
------------

// File: rtl/mult_share_arbiter_pkg.sv
// Shared defaults and width helpers for the multiplier-sharing arbiter.
package mult_pkg;

  localparam int N_DEF    = 32;
  localparam int NREQ_DEF = 4;
  localparam int PROD_W_DEF = 2 * N_DEF;

  // Requester ID width; never narrower than one bit so a 2-way build still has an index.
  function automatic int id_width(input int nreq);
    return (nreq <= 2) ? 1 : $clog2(nreq);
  endfunction

  function automatic int prod_width(input int n);
    return 2 * n;
  endfunction

endpackage

// File: rtl/mult_share_arbiter_rr.sv
// Combinational round-robin arbiter: first set request at or above ptr, with wrap.
module rr_arbiter
  import mult_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = id_width(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  logic found;
  int   idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/signed_mult_core.sv
// Signed combinational NxN multiplier with a full-width 2N-bit product.
module signed_mult_core #(
  parameter int N = mult_pkg::N_DEF
) (
  input  logic signed [N-1:0]   a,
  input  logic signed [N-1:0]   b,
  output logic signed [2*N-1:0] p
);

  // Both operands are signed, so they are sign-extended to the 2N result context.
  assign p = a * b;

endmodule

// File: rtl/mult_share_arbiter.sv
// One signed multiplier shared by NREQ requesters through a round-robin arbiter
// and a single backpressured response register.
module mult_share_arbiter
  import mult_pkg::*;
#(
  parameter int N    = N_DEF,
  parameter int NREQ = NREQ_DEF,
  localparam int IDW = id_width(NREQ),
  localparam int PW  = prod_width(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*N-1:0] req_a,
  input  logic [NREQ*N-1:0] req_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [PW-1:0]     rsp_prod,
  output logic [15:0]       ops_done
);

  logic [IDW-1:0]       rr_ptr;
  logic [NREQ-1:0]      gnt;
  logic [IDW-1:0]       gnt_idx;
  logic                 slot_free;
  logic                 accept;
  logic signed [N-1:0]  a_sel;
  logic signed [N-1:0]  b_sel;
  logic signed [PW-1:0] prod;
  int                   sel_i;

  assign slot_free = !rsp_valid || rsp_ready;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Grants are withheld during reset so nobody handshakes into a register being cleared.
  assign req_ready = gnt & {NREQ{slot_free & rst_n}};
  assign accept    = |req_ready;

  always_comb begin
    sel_i = int'(gnt_idx);
    a_sel = req_a[sel_i*N +: N];
    b_sel = req_b[sel_i*N +: N];
  end

  signed_mult_core #(.N(N)) u_mul (
    .a (a_sel),
    .b (b_sel),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_prod  <= '0;
      ops_done  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (rsp_valid && rsp_ready) ops_done <= ops_done + 16'd1;
      // A new accept overwrites a draining slot in the same cycle, so no bubble.
      if (accept) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_idx;
        rsp_prod  <= prod;
        rr_ptr    <= (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed self-checking bench for mult_share_arbiter (N=32, NREQ=4).
module tb_mult_share_arbiter;

  localparam int N    = 32;
  localparam int NREQ = 4;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_a;
  logic [NREQ*N-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [1:0]        rsp_id;
  logic [2*N-1:0]    rsp_prod;
  logic [15:0]       ops_done;

  int checks;
  int errors;

  mult_share_arbiter #(.N(N), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_prod  (rsp_prod),
    .ops_done  (ops_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    req_a[i*N +: N] = a;
    req_b[i*N +: N] = b;
  endtask

  logic [31:0] va [7];
  logic [31:0] vb [7];
  logic [63:0] vp [7];
  logic [1:0]  rr_ids [5];
  logic [63:0] rr_prods [5];

  initial begin
    checks = 0;
    errors = 0;
    va[0] = 32'd5;            vb[0] = 32'd6;            vp[0] = 64'd30;
    va[1] = -32'sd4;          vb[1] = -32'sd7;          vp[1] = 64'd28;
    va[2] = 32'd10;           vb[2] = -32'sd4;          vp[2] = -64'sd40;
    va[3] = -32'sd50;         vb[3] = 32'd5;            vp[3] = -64'sd250;
    va[4] = 32'd1234;         vb[4] = 32'd0;            vp[4] = 64'd0;
    va[5] = 32'd99;           vb[5] = 32'd1;            vp[5] = 64'd99;
    va[6] = 32'h8000_0000;    vb[6] = 32'h8000_0000;    vp[6] = 64'h4000_0000_0000_0000;
    rr_ids[0] = 2'd0; rr_ids[1] = 2'd1; rr_ids[2] = 2'd2; rr_ids[3] = 2'd3; rr_ids[4] = 2'd0;
    rr_prods[0] = 64'd10; rr_prods[1] = 64'd20; rr_prods[2] = 64'd30;
    rr_prods[3] = 64'd40; rr_prods[4] = 64'd10;

    // Reset with every requester asking
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_a     = '0;
    req_b     = '0;
    for (int i = 0; i < NREQ; i++) set_op(i, 32'(i + 1), 32'd10);
    for (int c = 0; c < 2; c++) begin
      step();
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
      chk("rst_ops_done",  64'(ops_done),  64'h0);
    end
    rst_n = 1'b1;
    #1;
    chk("first_grant", 64'(req_ready), 64'b0001);

    // Round-robin, back-to-back
    for (int k = 0; k < 5; k++) begin
      step();
      chk("rr_valid", 64'(rsp_valid), 64'h1);
      chk("rr_id",    64'(rsp_id),    64'(rr_ids[k]));
      chk("rr_prod",  rsp_prod,       rr_prods[k]);
    end
    req_valid = 4'b0000;
    step();
    chk("rr_drain_valid", 64'(rsp_valid), 64'h0);
    chk("rr_ops_done",    64'(ops_done),  64'd5);

    // Signed products on requester 0 (rr_ptr is 1, search wraps to 0)
    req_valid = 4'b0001;
    for (int k = 0; k < 7; k++) begin
      set_op(0, va[k], vb[k]);
      step();
      chk("mul_prod", rsp_prod,       vp[k]);
      chk("mul_id",   64'(rsp_id),    64'h0);
    end
    req_valid = 4'b0000;
    step();
    chk("mul_ops_done", 64'(ops_done), 64'd12);

    // Backpressure: hold 3*7 on id 2, queue 6*7 on id 0
    req_valid = 4'b0100;
    set_op(2, 32'd3, 32'd7);
    step();
    chk("bp_first_id",   64'(rsp_id), 64'd2);
    chk("bp_first_prod", rsp_prod,    64'd21);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    set_op(0, 32'd6, 32'd7);
    #1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_ready_zero", 64'(req_ready), 64'h0);
      chk("bp_hold_valid", 64'(rsp_valid), 64'h1);
      chk("bp_hold_prod",  rsp_prod,       64'd21);
      chk("bp_hold_id",    64'(rsp_id),    64'd2);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 64'(req_ready), 64'b0001);
    step();
    chk("bp_next_valid", 64'(rsp_valid), 64'h1);
    chk("bp_next_id",    64'(rsp_id),    64'd0);
    chk("bp_next_prod",  rsp_prod,       64'd42);
    chk("bp_ops_done",   64'(ops_done),  64'd13);
    req_valid = 4'b0000;
    step();
    chk("bp_drain_valid", 64'(rsp_valid), 64'h0);

    // Wrap/fairness: move rr_ptr to 2 via requester 1, then contend 3 vs 1
    req_valid = 4'b0010;
    set_op(1, 32'd1, 32'd1);
    step();
    chk("wr_setup_id", 64'(rsp_id), 64'd1);
    req_valid = 4'b1010;
    #1;
    chk("wr_gnt_a", 64'(req_ready), 64'b1000);
    step();
    chk("wr_id_a", 64'(rsp_id), 64'd3);
    chk("wr_gnt_b", 64'(req_ready), 64'b0010);
    step();
    chk("wr_id_b", 64'(rsp_id), 64'd1);
    chk("wr_gnt_c", 64'(req_ready), 64'b1000);
    step();
    chk("wr_id_c", 64'(rsp_id), 64'd3);
    req_valid = 4'b0000;
    step();
    chk("wr_ops_done", 64'(ops_done), 64'd18);

    // Reset while a response is held under backpressure
    req_valid = 4'b0001;
    set_op(0, 32'd5, 32'd5);
    rsp_ready = 1'b0;
    step();
    chk("mr_held_prod", rsp_prod, 64'd25);
    req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("mr_ready_in_rst", 64'(req_ready), 64'h0);
    step();
    chk("mr_valid", 64'(rsp_valid), 64'h0);
    chk("mr_prod",  rsp_prod,       64'h0);
    chk("mr_id",    64'(rsp_id),    64'h0);
    chk("mr_ops",   64'(ops_done),  64'h0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("mr_ptr_zero", 64'(req_ready), 64'b0001);

    // Counter wrap: 65537 drained responses from reset
    req_valid = 4'b0001;
    set_op(0, 32'd2, 32'd3);
    for (int k = 1; k <= 65537; k++) begin
      step();
      if (k == 65536) chk("cnt_ffff", 64'(ops_done), 64'hFFFF);
    end
    req_valid = 4'b0000;
    step();
    chk("cnt_wrap", 64'(ops_done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
